// File: rtl/trng_pkg.sv
// trng_pkg: shared defaults and helpers for the TRNG word collector.
//   DEF_WORD_W      default output word width
//   DEF_FIFO_DEPTH  default number of buffered words
//   DEF_DROP_CNT_W  default width of the dropped-word counter
//   level_w()       width of a 0..depth occupancy count
package trng_pkg;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_DROP_CNT_W = 16;

  // One extra bit so that a completely full FIFO (level == depth) fits.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// trng_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   i_push        write request; taken when not full, or full with a pop
//   i_push_data   word to write
//   i_pop         read request; ignored when empty
//   o_pop_data    head word; holds the last shown word while empty
//   o_full        level == DEPTH
//   o_empty       level == 0
//   o_level       words held, 0..DEPTH
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_push_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_pop_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [level_w(DEPTH)-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_last;

  logic             w_pop;
  logic             w_wr;
  logic [WIDTH-1:0] w_head;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_wr    = i_push & (~o_full | w_pop);

  // While empty the output replays the last word shown, so it never shows
  // an unwritten slot.
  assign w_head     = o_empty ? r_last : r_mem[r_rd_ptr];
  assign o_pop_data = w_head;
  assign o_level    = r_level;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      r_last <= w_head;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: packs raw entropy bits MSB-first into WORD_W-bit words and
// buffers finished words in a FWFT FIFO with a valid/ready read side.
// Optional build macro: TRNG_VN_DEBIAS_EN adds a von Neumann corrector in
// front of the accumulator.
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   enable       collection enable; low clears the partial word only
//   bit_in       raw entropy bit, qualified by bit_valid
//   data_out     head-of-FIFO word (MSB = oldest bit)
//   data_valid   FIFO not empty
//   data_ready   consumer takes data_out this cycle
//   fifo_level   words held, 0..FIFO_DEPTH
//   drop_count   saturating count of words lost to a full FIFO
//   busy         partial word in the accumulator
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DROP_CNT_W = DEF_DROP_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           bit_in,
  input  logic                           bit_valid,
  output logic [WORD_W-1:0]              data_out,
  output logic                           data_valid,
  input  logic                           data_ready,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic [DROP_CNT_W-1:0]          drop_count,
  output logic                           busy
);

  localparam int CNT_W = $clog2(WORD_W);

  logic              w_raw;
  logic              w_acc_vld;
  logic              w_acc_bit;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [WORD_W-1:0] w_word;

  logic [WORD_W-1:0]     r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [DROP_CNT_W-1:0] r_drop;

  assign w_raw = enable & bit_valid;

`ifdef TRNG_VN_DEBIAS_EN
  logic r_pair_have;
  logic r_pair_bit;

  // Second bit of a pair: differing bits emit the first bit (01->0, 10->1).
  assign w_acc_vld = w_raw & r_pair_have & (r_pair_bit != bit_in);
  assign w_acc_bit = r_pair_bit;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_pair_have <= 1'b0;
      r_pair_bit  <= 1'b0;
    end else if (w_raw) begin
      r_pair_have <= ~r_pair_have;
      if (!r_pair_have) r_pair_bit <= bit_in;
    end
  end
`else
  assign w_acc_vld = w_raw;
  assign w_acc_bit = bit_in;
`endif

  assign w_word = {r_acc[WORD_W-2:0], w_acc_bit};
  assign w_push = w_acc_vld & (r_cnt == CNT_W'(WORD_W - 1));
  // Drop only when full and the head is not leaving on this edge.
  assign w_drop = w_push & w_full & ~(data_ready & ~w_empty);

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_acc_vld) begin
      r_acc <= w_word;
      r_cnt <= w_push ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != '1)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

  trng_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_word),
    .i_pop       (data_ready),
    .o_pop_data  (data_out),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );

  assign data_valid = ~w_empty;
  assign busy       = (r_cnt != '0);
  assign drop_count = r_drop;

endmodule

// File: tb/tb_trng_word_fifo.sv
module tb_trng_word_fifo;

`ifdef TRNG_VN_DEBIAS_EN
  localparam int W = 8;
`else
  localparam int W = 32;
`endif
  localparam int D  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          bit_in;
  logic          bit_valid;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          data_ready;
  logic [2:0]    fifo_level;
  logic [DW-1:0] drop_count;
  logic          busy;

  int total = 0;
  int bad   = 0;

  trng_word_fifo #(
    .WORD_W     (W),
    .FIFO_DEPTH (D),
    .DROP_CNT_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feed the top n bits of w, MSB first, one per cycle.
  task automatic feed_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bit_in    = w[31-i];
      bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
  endtask

`ifndef TRNG_VN_DEBIAS_EN
  logic [31:0] ovf [6];
  logic [31:0] full_w [4];
`else
  logic [1:0] pairs [10];
`endif

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    data_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_data",  64'(data_out),   64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop",  64'(drop_count), 64'd0);
    chk("rst_busy",  64'(busy),       64'd0);
    rst_n = 1'b1;
    step();

`ifndef TRNG_VN_DEBIAS_EN
    // First word, no consumer.
    feed_word(32'hA5A5A5A5, 31);
    chk("a5_busy_mid",  64'(busy),       64'd1);
    chk("a5_valid_mid", 64'(data_valid), 64'd0);
    bit_in = 1'b1; bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
    chk("a5_valid", 64'(data_valid), 64'd1);
    chk("a5_data",  64'(data_out),   64'hA5A5A5A5);
    chk("a5_level", 64'(fifo_level), 64'd1);
    chk("a5_busy",  64'(busy),       64'd0);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk("a5_pop_valid", 64'(data_valid), 64'd0);
    chk("a5_pop_level", 64'(fifo_level), 64'd0);
    chk("a5_hold_data", 64'(data_out),   64'hA5A5A5A5);

    // bit_valid on every other cycle: 32 bits over 64 cycles.
    bit_in = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bit_valid = (i % 2 == 0);
      step();
      if (i == 61) begin
        chk("tog_valid_31", 64'(data_valid), 64'd0);
        chk("tog_busy_31",  64'(busy),       64'd1);
      end
    end
    bit_valid = 1'b0;
    chk("tog_data",  64'(data_out),   64'hFFFFFFFF);
    chk("tog_level", 64'(fifo_level), 64'd1);
    chk("tog_busy",  64'(busy),       64'd0);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;

    // Overflow: six words into a four-deep FIFO.
    for (int k = 0; k < 6; k++) begin
      ovf[k] = 32'hC0DE0000 | 32'(k * 17 + 3);
      feed_word(ovf[k], 32);
    end
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_drop",  64'(drop_count), 64'd2);
    data_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_rd_valid", 64'(data_valid), 64'd1);
      chk("ovf_rd_data",  64'(data_out),   64'(ovf[k]));
      step();
    end
    data_ready = 1'b0;
    chk("ovf_empty", 64'(data_valid), 64'd0);
    chk("ovf_level0", 64'(fifo_level), 64'd0);

    // Full FIFO, word completes on the same edge as a pop.
    full_w[0] = 32'h01020304;
    full_w[1] = 32'h8899AABB;
    full_w[2] = 32'h0F0F00FF;
    full_w[3] = 32'hFEEDFACE;
    for (int k = 0; k < 4; k++) feed_word(full_w[k], 32);
    chk("fp_level_full", 64'(fifo_level), 64'd4);
    feed_word(32'h5EC0DE5A, 31);
    bit_in = 1'b0; bit_valid = 1'b1; data_ready = 1'b1;
    step();
    bit_valid = 1'b0;
    chk("fp_level", 64'(fifo_level), 64'd4);
    chk("fp_drop",  64'(drop_count), 64'd2);
    chk("fp_rd0", 64'(data_out), 64'(full_w[1]));
    step();
    chk("fp_rd1", 64'(data_out), 64'(full_w[2]));
    step();
    chk("fp_rd2", 64'(data_out), 64'(full_w[3]));
    step();
    chk("fp_rd3", 64'(data_out), 64'h5EC0DE5A);
    step();
    data_ready = 1'b0;
    chk("fp_empty", 64'(data_valid), 64'd0);

    // Partial word thrown away by dropping enable.
    feed_word(32'hFFFFFFFF, 10);
    chk("en_busy_part", 64'(busy), 64'd1);
    enable = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    enable = 1'b1; bit_valid = 1'b0;
    chk("en_busy_clr", 64'(busy), 64'd0);
    feed_word(32'h12345678, 32);
    chk("en_data",  64'(data_out),   64'h12345678);
    chk("en_level", 64'(fifo_level), 64'd1);

    // Reset mid-word with two words queued.
    feed_word(32'hDEADBEEF, 32);
    chk("rs_level2", 64'(fifo_level), 64'd2);
    feed_word(32'hFFFFFFFF, 5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rs_valid", 64'(data_valid), 64'd0);
    chk("rs_level", 64'(fifo_level), 64'd0);
    chk("rs_drop",  64'(drop_count), 64'd0);
    chk("rs_busy",  64'(busy),       64'd0);
`else
    // Pairs 01,10,11,00,10,10,01,01,10,01 emit 0,1,-,-,1,1,0,0,1,0 = 8'h72.
    pairs[0] = 2'b01; pairs[1] = 2'b10; pairs[2] = 2'b11; pairs[3] = 2'b00;
    pairs[4] = 2'b10; pairs[5] = 2'b10; pairs[6] = 2'b01; pairs[7] = 2'b01;
    pairs[8] = 2'b10; pairs[9] = 2'b01;
    bit_valid = 1'b1;
    for (int p = 0; p < 10; p++) begin
      for (int b = 0; b < 2; b++) begin
        bit_in = pairs[p][1-b];
        step();
      end
      if (p == 1) chk("vn_busy_2", 64'(busy), 64'd1);
      if (p == 3) begin
        chk("vn_busy_4",  64'(busy),       64'd1);
        chk("vn_valid_4", 64'(data_valid), 64'd0);
      end
      if (p == 8) chk("vn_valid_9", 64'(data_valid), 64'd0);
    end
    bit_valid = 1'b0;
    chk("vn_valid", 64'(data_valid), 64'd1);
    chk("vn_data",  64'(data_out),   64'h72);
    chk("vn_level", 64'(fifo_level), 64'd1);
    chk("vn_busy",  64'(busy),       64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
